// File: rtl/conv_mx_sched.sv
// Two-requester scheduler for a shared fixed-latency bf16-to-MX converter, with per-requester response FIFOs.
// Optional perf counters (grants, credit stalls) are built when CONV_MX_SCHED_PERF_EN is defined.
module conv_mx_sched #(
    parameter int k          = 32,
    parameter int bit_width  = 6,
    parameter int conv_lat   = 2,
    parameter int fifo_depth = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_req_valid,
    output logic [1:0]           o_req_ready,
    input  logic [15:0]          i_req_vec     [2][k],
    output logic [15:0]          o_conv_vec    [k],
    input  logic [bit_width-1:0] i_conv_mx_vec [k],
    input  logic [7:0]           i_conv_mx_exp,
    output logic [1:0]           o_rsp_valid,
    input  logic [1:0]           i_rsp_ready,
    output logic [bit_width-1:0] o_rsp_vec     [2][k],
    output logic [7:0]           o_rsp_exp     [2]
`ifdef CONV_MX_SCHED_PERF_EN
    ,
    output logic [31:0]          o_grant_cnt        [2],
    output logic [31:0]          o_credit_stall_cnt [2]
`endif
);

    localparam int ptr_w = $clog2(fifo_depth);
    localparam int dw    = k * bit_width + 8;
    localparam int last  = conv_lat - 1;
    localparam logic [ptr_w:0]   cnt_one = 1;
    localparam logic [ptr_w-1:0] ptr_one = 1;

    logic [ptr_w:0]   fifo_cnt [2];
    logic [ptr_w-1:0] wr_ptr   [2];
    logic [ptr_w-1:0] rd_ptr   [2];
    logic [dw-1:0]    mem      [2][fifo_depth];
    logic             tag_vld  [conv_lat];
    logic             tag_id   [conv_lat];
    logic [3:0]       inflight [2];
    logic             rr;
    logic             sel_q;
    logic             gid;
    logic             grant_any;
    logic [1:0]       elig;
    logic [1:0]       grant;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [dw-1:0]    push_word;

    // Credits count FIFO entries plus tags still travelling through the converter.
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            inflight[r] = '0;
            for (int s = 0; s < conv_lat; s++)
                if (tag_vld[s] && (tag_id[s] == 1'(r)))
                    inflight[r] = inflight[r] + 4'd1;
            elig[r] = i_req_valid[r] &&
                      ((32'(fifo_cnt[r]) + 32'(inflight[r])) < 32'(fifo_depth));
            push[r] = tag_vld[last] && (tag_id[last] == 1'(r));
            pop[r]  = (fifo_cnt[r] != '0) && i_rsp_ready[r];
        end
    end

    always_comb begin
        grant_any   = |elig;
        gid         = elig[0] ? (elig[1] ? rr : 1'b0) : 1'b1;
        grant       = grant_any ? (gid ? 2'b10 : 2'b01) : 2'b00;
        o_req_ready = i_rst ? 2'b00 : grant;
    end

    // Without a grant the mux stays on the last granted requester; the value is untagged.
    always_comb begin
        for (int j = 0; j < k; j++)
            o_conv_vec[j] = i_rst ? 16'h0000 : i_req_vec[grant_any ? gid : sel_q][j];
    end

    always_comb begin
        push_word = '0;
        for (int j = 0; j < k; j++)
            push_word[j*bit_width +: bit_width] = i_conv_mx_vec[j];
        push_word[dw-1 -: 8] = i_conv_mx_exp;
    end

    always_comb begin
        for (int r = 0; r < 2; r++) begin
            o_rsp_valid[r] = (fifo_cnt[r] != '0);
            o_rsp_exp[r]   = mem[r][rd_ptr[r]][dw-1 -: 8];
            for (int j = 0; j < k; j++)
                o_rsp_vec[r][j] = mem[r][rd_ptr[r]][j*bit_width +: bit_width];
        end
    end

    always_ff @(posedge i_clk) begin
        for (int r = 0; r < 2; r++)
            if (push[r])
                mem[r][wr_ptr[r]] <= push_word;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr    <= 1'b0;
            sel_q <= 1'b0;
            for (int s = 0; s < conv_lat; s++) begin
                tag_vld[s] <= 1'b0;
                tag_id[s]  <= 1'b0;
            end
            for (int r = 0; r < 2; r++) begin
                wr_ptr[r]   <= '0;
                rd_ptr[r]   <= '0;
                fifo_cnt[r] <= '0;
            end
        end else begin
            if (grant_any) begin
                rr    <= ~gid;
                sel_q <= gid;
            end
            tag_vld[0] <= grant_any;
            tag_id[0]  <= gid;
            for (int s = 1; s < conv_lat; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
            for (int r = 0; r < 2; r++) begin
                if (push[r])
                    wr_ptr[r] <= wr_ptr[r] + ptr_one;
                if (pop[r])
                    rd_ptr[r] <= rd_ptr[r] + ptr_one;
                case ({push[r], pop[r]})
                    2'b10:   fifo_cnt[r] <= fifo_cnt[r] + cnt_one;
                    2'b01:   fifo_cnt[r] <= fifo_cnt[r] - cnt_one;
                    default: fifo_cnt[r] <= fifo_cnt[r];
                endcase
            end
        end
    end

`ifdef CONV_MX_SCHED_PERF_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < 2; r++) begin
                o_grant_cnt[r]        <= '0;
                o_credit_stall_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (grant[r] && (o_grant_cnt[r] != 32'hFFFF_FFFF))
                    o_grant_cnt[r] <= o_grant_cnt[r] + 32'd1;
                if (i_req_valid[r] && !elig[r] && (o_credit_stall_cnt[r] != 32'hFFFF_FFFF))
                    o_credit_stall_cnt[r] <= o_credit_stall_cnt[r] + 32'd1;
            end
        end
    end
`endif

endmodule
